// File: rtl/key_debounce_pulse_if.sv
// key_debounce_pulse_if: push-button conditioner signal bundle.
//   key   : raw push-button, active-low, asynchronous to clk
//   level : debounced pressed state, 1 = pressed
//   pulse : one-cycle strobe per accepted press (and per repeat when enabled)
// master drives key and observes outputs; slave is the conditioner itself.
interface key_debounce_pulse_if;
    logic key;
    logic level;
    logic pulse;

    modport master (output key, input level, input pulse);
    modport slave  (input key, output level, output pulse);
endinterface

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: conditions a raw, bouncing, active-low push-button into a
// clean pressed level and a one-cycle pulse usable as a counter enable.
// Two-FF synchronizer followed by a debounce FSM with a consecutive-sample counter.
// Ports:
//   clk       : board clock, all state updates on posedge
//   clr       : asynchronous, active-high reset
//   bus.key   : raw push-button, active-low (0 = pressed)
//   bus.level : debounced pressed state, registered
//   bus.pulse : registered one-cycle strobe on each accepted press
// Optional feature: define KEY_REPEAT_EN for auto-repeat pulses while held.
module key_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned RPT_W           = 25
) (
    input  logic                 clk,
    input  logic                 clr,
    key_debounce_pulse_if.slave  bus
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam longint unsigned  RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                            64'(REPEAT_DELAY) : 64'(REPEAT_PERIOD);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if ((64'(1) << RPT_W) <= RPT_MAX) begin : g_bad_rpt_w
        $error("RPT_W too narrow for repeat timing");
    end

    logic [1:0]       sync_q;
    logic             p;
    logic [1:0]       state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_q, level_next;
    logic             pulse_q, pulse_next;

`ifdef KEY_REPEAT_EN
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
    logic [RPT_W-1:0] rc, rc_next;
    logic             rpt_phase, rpt_phase_next;   // 0: waiting first delay, 1: periodic
`endif

    // Two-FF synchronizer; resets to the released level
    always_ff @(posedge clk or posedge clr) begin
        if (clr) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.key};
    end

    assign p = ~sync_q[1];

    // State and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            level_q <= level_next;
            pulse_q <= pulse_next;
        end
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat counter registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rc        <= '0;
            rpt_phase <= 1'b0;
        end else begin
            rc        <= rc_next;
            rpt_phase <= rpt_phase_next;
        end
    end
`endif

    // Next-state, counter and output decode
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (p) begin
                    next_state = PRESS_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = HELD;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!p) begin
                    next_state = RELEASE_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (p) begin
                    next_state = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase

`ifdef KEY_REPEAT_EN
        // Repeat timing runs only across cycles that stay in HELD; any exit or
        // fresh entry restarts at the initial-delay phase.
        rc_next        = '0;
        rpt_phase_next = 1'b0;
        if (state == HELD && next_state == HELD) begin
            if (rc == (rpt_phase ? RP_LAST : RD_LAST)) begin
                pulse_next     = 1'b1;
                rpt_phase_next = 1'b1;
            end else begin
                rc_next        = rc + RPT_W'(1);
                rpt_phase_next = rpt_phase;
            end
        end
`endif

        level_next = (next_state == HELD) || (next_state == RELEASE_WAIT);
    end

    assign bus.level = level_q;
    assign bus.pulse = pulse_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed scenarios with literal expectations plus a
// randomized key stream checked every cycle against a run-length reference model.
module tb_key_debounce_pulse;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   tests = 0;
    int   fails = 0;

    key_debounce_pulse_if bus();

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .RPT_W(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the synchronized press signal is the key sampled two
    // edges earlier; level flips once D consecutive samples disagree with it.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    logic m_level = 1'b0, m_pulse = 1'b0;
    int   m_run = 0;
    int   m_hold = 0;
    logic mp, staying;

    initial begin
        forever begin
            @(posedge clk or posedge clr);
            if (clr) begin
                m_s1 = 1'b1; m_s2 = 1'b1;
                m_level = 1'b0; m_pulse = 1'b0;
                m_run = 0; m_hold = 0;
            end else begin
                mp      = ~m_s2;
                m_s2    = m_s1;
                m_s1    = bus.key;
                m_pulse = 1'b0;
                staying = m_level && (m_run == 0) && mp;
                if (mp != m_level) begin
                    m_run++;
                    if (m_run == D) begin
                        m_level = mp;
                        m_run   = 0;
                        m_pulse = mp;
                    end
                end else begin
                    m_run = 0;
                end
                if (REP && staying) begin
                    m_hold++;
                    if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0))
                        m_pulse = 1'b1;
                end else begin
                    m_hold = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    logic prev_pulse = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            check("model_level", bus.level, m_level);
            check("model_pulse", bus.pulse, m_pulse);
            check("pulse_back_to_back", prev_pulse & bus.pulse, 1'b0);
            prev_pulse = bus.pulse;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pulses;
    int len;

    initial begin
        bus.key = 1'b1;
        clr     = 1'b1;
        #1;
        check("reset_level", bus.level, 1'b0);
        check("reset_pulse", bus.pulse, 1'b0);
        cyc(3);
        clr = 1'b0;
        cyc(3);

        // Clean press: outputs rise at edge 6
        bus.key = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("press_level", bus.level, logic'(i >= 6));
            check("press_pulse", bus.pulse, logic'(i == 6));
        end
        cyc(1);
        bus.key = 1'b1;
        cyc(10);

        // Short bounce is rejected, then a clean press yields one pulse
        bus.key = 1'b0;
        cyc(3);
        bus.key = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("bounce_level", bus.level, 1'b0);
            check("bounce_pulse", bus.pulse, 1'b0);
        end
        cyc(1);
        bus.key = 1'b0;
        pulses  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            pulses += int'(bus.pulse);
        end
        check_int("clean_press_pulses", pulses, 1);
        check("clean_press_level", bus.level, 1'b1);
        cyc(1);
        bus.key = 1'b1;
        cyc(10);

        // Release bounce keeps level and produces no new pulse; full release drops level
        bus.key = 1'b0;
        cyc(8);
        bus.key = 1'b1;
        cyc(2);
        bus.key = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("rel_bounce_level", bus.level, 1'b1);
            check("rel_bounce_pulse", bus.pulse, 1'b0);
        end
        cyc(1);
        bus.key = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            check("release_level", bus.level, logic'(i < 6));
        end
        cyc(5);

        // Reset while held, key still low: fresh debounce after reset releases
        bus.key = 1'b0;
        cyc(8);
        #2 clr = 1'b1;
        #1;
        check("clr_held_level", bus.level, 1'b0);
        check("clr_held_pulse", bus.pulse, 1'b0);
        cyc(2);
        clr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("post_clr_pulse", bus.pulse, logic'(i == 6));
            check("post_clr_level", bus.level, logic'(i >= 6));
        end
        cyc(1);

        // Reset mid-run with key released afterwards: outputs stay low
        #2 clr = 1'b1;
        #1;
        check("clr_mid_level", bus.level, 1'b0);
        @(negedge clk);
        clr     = 1'b0;
        bus.key = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("idle_after_clr_level", bus.level, 1'b0);
            check("idle_after_clr_pulse", bus.pulse, 1'b0);
        end
        cyc(5);

        // Long hold: auto-repeat at offsets 10,13,...,28 after the first pulse when enabled
        bus.key = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            @(posedge clk); #1;
            check("hold_pulse", bus.pulse,
                  logic'(i == 6 || (REP && i >= 16 && ((i - 16) % 3) == 0)));
        end
        cyc(1);
        bus.key = 1'b1;
        cyc(10);

        // Randomized key stream with occasional asynchronous reset
        for (int s = 0; s < 500; s++) begin
            bus.key = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) len = int'($urandom_range(10, 30));
            else                           len = int'($urandom_range(1, 6));
            cyc(len);
            if ($urandom_range(0, 40) == 0) begin
                #2 clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end
        end

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
